// File: rtl/ssp_pkg.sv
// Shared types and constants for the SSP transmit path.
package ssp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    SHIFT = 2'd2
  } ssp_tx_state_t;

  localparam int SSP_DATA_WIDTH = 8;
  localparam int SSP_CNT_WIDTH  = $clog2(SSP_DATA_WIDTH);

endpackage

// File: rtl/ssp_tx_shreg.sv
// Transmit shift register with a one-word holding register for back-to-back frames.
module ssp_tx_shreg
  import ssp_pkg::*;
#(
  parameter int DATA_WIDTH = SSP_DATA_WIDTH
) (
  input  logic                  PCLK,
  input  logic                  CLEAR_B,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  capture,
  input  logic                  promote,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  msb,
  output logic                  next_msb,
  output logic                  pending
);

  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] nxt;

  // Promote moves the held word in already shifted once, since its MSB goes straight to the pin.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      sh      <= '0;
      nxt     <= '0;
      pending <= 1'b0;
    end else begin
      if (load)
        sh <= din;
      else if (promote)
        sh <= {nxt[DATA_WIDTH-2:0], 1'b0};
      else if (shift)
        sh <= {sh[DATA_WIDTH-2:0], 1'b0};

      if (capture) begin
        nxt     <= din;
        pending <= 1'b1;
      end else if (promote) begin
        pending <= 1'b0;
      end
    end
  end

  assign msb      = sh[DATA_WIDTH-1];
  assign next_msb = nxt[DATA_WIDTH-1];

endmodule

// File: rtl/ssp_tx_ctrl.sv
// SSP transmit sequencer: pops the TX FIFO and drives frame sync, data and output enable on serial ticks.
module ssp_tx_ctrl
  import ssp_pkg::*;
#(
  parameter int DATA_WIDTH = SSP_DATA_WIDTH
) (
  input  logic                  PCLK,
  input  logic                  CLEAR_B,
  input  logic                  SSPCLKOUT,
  input  logic                  tx_empty,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_pop,
  output logic                  SSPFSSOUT,
  output logic                  SSPTXD,
  output logic                  SSPOE_B,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ssp_tx_state_t    state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             fss, fss_d, txd, txd_d, oe_b, oe_b_d;
  logic             tick;
  logic             load, shift, capture, promote;
  logic             msb, next_msb, pending;

  // Reset gating keeps tx_pop quiet while SSPCLKOUT is parked low in reset.
  assign tick = CLEAR_B & ~SSPCLKOUT;

  ssp_tx_shreg #(.DATA_WIDTH(DATA_WIDTH)) u_shreg (
    .PCLK     (PCLK),
    .CLEAR_B  (CLEAR_B),
    .load     (load),
    .shift    (shift),
    .capture  (capture),
    .promote  (promote),
    .din      (tx_data),
    .msb      (msb),
    .next_msb (next_msb),
    .pending  (pending)
  );

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state <= IDLE;
      cnt   <= '0;
      fss   <= 1'b0;
      txd   <= 1'b0;
      oe_b  <= 1'b1;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      fss   <= fss_d;
      txd   <= txd_d;
      oe_b  <= oe_b_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    fss_d   = fss;
    txd_d   = txd;
    oe_b_d  = oe_b;
    tx_pop  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    capture = 1'b0;
    promote = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!tx_empty) begin
            tx_pop  = 1'b1;
            load    = 1'b1;
            fss_d   = 1'b1;
            state_d = SYNC;
          end
        end
        SYNC: begin
          fss_d   = 1'b0;
          oe_b_d  = 1'b0;
          txd_d   = msb;
          shift   = 1'b1;
          cnt_d   = CNT_LAST;
          state_d = SHIFT;
        end
        SHIFT: begin
          if (cnt != '0) begin
            txd_d = msb;
            shift = 1'b1;
            cnt_d = cnt - CNT_ONE;
            // Fetching the next word while bit 0 goes out lets its sync overlap the LSB.
            if (cnt == CNT_ONE && !tx_empty) begin
              tx_pop  = 1'b1;
              capture = 1'b1;
              fss_d   = 1'b1;
            end
          end else if (pending) begin
            fss_d   = 1'b0;
            promote = 1'b1;
            txd_d   = next_msb;
            cnt_d   = CNT_LAST;
          end else begin
            txd_d   = 1'b0;
            oe_b_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign SSPFSSOUT = fss;
  assign SSPTXD    = txd;
  assign SSPOE_B   = oe_b;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ssp_tx_ctrl.sv
// Directed bench for ssp_tx_ctrl at DATA_WIDTH 8 and 4, sharing clock and reset.
module tb_ssp_tx_ctrl;

  logic       PCLK = 1'b0;
  logic       CLEAR_B = 1'b0;
  logic       sclk = 1'b0;
  logic       empty8, empty4;
  logic [7:0] data8;
  logic [3:0] data4;
  logic       pop8, fss8, txd8, oe8, busy8;
  logic       pop4, fss4, txd4, oe4, busy4;
  int         total = 0;
  int         bad = 0;
  int         pops8 = 0;
  int         pops4 = 0;
  int         cyc = 0;
  int         t0;
  logic [7:0]  w8;
  logic [15:0] stream;
  logic [3:0]  w4;

  ssp_tx_ctrl #(.DATA_WIDTH(8)) dut8 (
    .PCLK(PCLK), .CLEAR_B(CLEAR_B), .SSPCLKOUT(sclk), .tx_empty(empty8), .tx_data(data8),
    .tx_pop(pop8), .SSPFSSOUT(fss8), .SSPTXD(txd8), .SSPOE_B(oe8), .busy(busy8)
  );

  ssp_tx_ctrl #(.DATA_WIDTH(4)) dut4 (
    .PCLK(PCLK), .CLEAR_B(CLEAR_B), .SSPCLKOUT(sclk), .tx_empty(empty4), .tx_data(data4),
    .tx_pop(pop4), .SSPFSSOUT(fss4), .SSPTXD(txd4), .SSPOE_B(oe4), .busy(busy4)
  );

  always #5 PCLK = ~PCLK;

  // Divider model: PCLK/2, parked low in reset
  always @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) sclk <= 1'b0;
    else          sclk <= ~sclk;
  end

  always @(posedge PCLK) begin
    cyc <= cyc + 1;
    if (pop8) pops8 <= pops8 + 1;
    if (pop4) pops4 <= pops4 + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic e8, input logic [7:0] d8, input logic e4, input logic [3:0] d4);
    empty8 = e8;
    data8  = d8;
    empty4 = e4;
    data4  = d4;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b0, 8'hA5, 1'b1, 4'h0);
    CLEAR_B = 1'b0;
    repeat (4) @(negedge PCLK);
    checkOutput("rst_fss", fss8, 0);
    checkOutput("rst_txd", txd8, 0);
    checkOutput("rst_oe", oe8, 1);
    checkOutput("rst_busy", busy8, 0);
    checkOutput("rst_pop", pop8, 0);
    checkOutput("rst_popcnt", pops8, 0);

    CLEAR_B = 1'b1;
    #1;
    checkOutput("rel_pop_comb", pop8, 1);
    @(negedge PCLK);
    checkOutput("rel_popcnt", pops8, 1);
    checkOutput("single_fss_rise", fss8, 1);
    checkOutput("single_busy", busy8, 1);
    checkOutput("single_pop_off", pop8, 0);
    applyStimulus(1'b1, 8'hA5, 1'b1, 4'h0);
    @(negedge PCLK);
    checkOutput("single_fss_hold", fss8, 1);
    checkOutput("single_oe_pre", oe8, 1);
    w8 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      @(negedge PCLK);
      checkOutput($sformatf("single_txd_b%0d_a", 7 - i), txd8, w8[7 - i]);
      checkOutput("single_oe_low", oe8, 0);
      checkOutput("single_fss_low", fss8, 0);
      @(negedge PCLK);
      checkOutput($sformatf("single_txd_b%0d_b", 7 - i), txd8, w8[7 - i]);
    end
    @(negedge PCLK);
    checkOutput("single_oe_rise", oe8, 1);
    checkOutput("single_txd_idle", txd8, 0);
    checkOutput("single_busy_end", busy8, 0);
    checkOutput("single_popcnt", pops8, 1);

    // SSPCLKOUT is high here, so the start takes two edges
    applyStimulus(1'b0, 8'h3C, 1'b1, 4'h0);
    @(negedge PCLK);
    checkOutput("phaseA_fss_early", fss8, 0);
    @(negedge PCLK);
    checkOutput("phaseA_fss_rise", fss8, 1);
    t0 = cyc;
    data8 = 8'hC3;
    @(negedge PCLK);
    checkOutput("b2b_fss_hold", fss8, 1);
    stream = 16'h3CC3;
    for (int k = 0; k < 16; k++) begin
      @(negedge PCLK);
      checkOutput($sformatf("b2b_txd_%0d_a", k), txd8, stream[15 - k]);
      checkOutput($sformatf("b2b_fss_%0d_a", k), fss8, (k == 7) ? 1 : 0);
      checkOutput("b2b_oe_low", oe8, 0);
      if (k == 7) empty8 = 1'b1;
      @(negedge PCLK);
      checkOutput($sformatf("b2b_txd_%0d_b", k), txd8, stream[15 - k]);
      checkOutput($sformatf("b2b_fss_%0d_b", k), fss8, (k == 7) ? 1 : 0);
    end
    @(negedge PCLK);
    checkOutput("b2b_oe_rise", oe8, 1);
    checkOutput("b2b_span", cyc - t0, 34);
    checkOutput("b2b_popcnt", pops8, 3);
    checkOutput("b2b_busy_end", busy8, 0);

    // SSPCLKOUT is low after this edge, so the start takes one edge
    @(negedge PCLK);
    applyStimulus(1'b0, 8'hFF, 1'b1, 4'h0);
    #1;
    checkOutput("phaseB_fss_pre", fss8, 0);
    @(negedge PCLK);
    checkOutput("phaseB_fss_rise", fss8, 1);
    empty8 = 1'b1;
    repeat (9) @(negedge PCLK);
    checkOutput("midrst_txd_pre", txd8, 1);
    checkOutput("midrst_oe_pre", oe8, 0);
    CLEAR_B = 1'b0;
    #1;
    checkOutput("midrst_fss", fss8, 0);
    checkOutput("midrst_txd", txd8, 0);
    checkOutput("midrst_oe", oe8, 1);
    checkOutput("midrst_busy", busy8, 0);
    @(negedge PCLK);
    CLEAR_B = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      checkOutput("post_rst_busy", busy8, 0);
      checkOutput("post_rst_oe", oe8, 1);
    end
    checkOutput("post_rst_popcnt", pops8, 4);

    for (int i = 0; i < 2 && sclk !== 1'b0; i++) @(negedge PCLK);
    applyStimulus(1'b1, 8'h00, 1'b0, 4'h9);
    @(negedge PCLK);
    checkOutput("w4_fss_rise", fss4, 1);
    t0 = cyc;
    empty4 = 1'b1;
    @(negedge PCLK);
    checkOutput("w4_fss_hold", fss4, 1);
    w4 = 4'h9;
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      checkOutput($sformatf("w4_txd_b%0d_a", 3 - k), txd4, w4[3 - k]);
      checkOutput("w4_oe_low", oe4, 0);
      @(negedge PCLK);
      checkOutput($sformatf("w4_txd_b%0d_b", 3 - k), txd4, w4[3 - k]);
    end
    @(negedge PCLK);
    checkOutput("w4_oe_rise", oe4, 1);
    checkOutput("w4_span", cyc - t0, 10);
    checkOutput("w4_popcnt", pops4, 1);
    checkOutput("w4_busy_end", busy4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ssp_tx_ctrl.md
# ssp_tx_ctrl

Transmit-side sequencer for the SSP controller. Pulls bytes from the transmit FIFO and drives the serial frame (SSPFSSOUT, SSPTXD, SSPOE_B) in lock-step with SSPCLKOUT, the PCLK/2 serial clock from the existing clock divider. It sits between the TX FIFO and the SSP pins, in the PCLK domain. It schedules every frame start and every bit launch relative to the divided clock.

## Interface

- DATA_WIDTH, 8, bits per frame; legal range 4..16.

- PCLK  in  1  system clock; sole clock of the block.
- CLEAR_B  in  1  reset; asynchronous, active-low.
- SSPCLKOUT  in  1  serial clock from the divider; toggles every PCLK edge when not in reset; 0 during reset.
- tx_empty  in  1  TX FIFO empty flag.
- tx_data  in  DATA_WIDTH  TX FIFO head word; first-word-fall-through, valid whenever tx_empty=0.
- tx_pop  out  1  FIFO read strobe; one PCLK cycle wide, combinational.
- SSPFSSOUT  out  1  frame sync; high for one serial period before each frame's MSB.
- SSPTXD  out  1  serial data, MSB first.
- SSPOE_B  out  1  pad output enable, active-low; low while data bits are driven.
- busy  out  1  high in any state other than IDLE.

## Operation

- **Tick:** a PCLK rising edge at which the pre-edge SSPCLKOUT value is 0, so the edge coincides with SSPCLKOUT 0→1. All registered outputs change only on ticks.
- **Reset values:** SSPFSSOUT=0, SSPTXD=0, SSPOE_B=1, busy=0, tx_pop=0, state=IDLE, bit counter=0.
- **IDLE**
  - On a tick with tx_empty=0: tx_pop=1, capture tx_data into the shift register, SSPFSSOUT←1, go to SYNC.
  - tx_empty=1: remain in IDLE with outputs at their reset values.
- **SYNC**
  - On a tick: SSPFSSOUT←0, SSPOE_B←0, SSPTXD←bit DATA_WIDTH-1, counter←DATA_WIDTH-1, go to SHIFT.
- **SHIFT**
  - On each tick with counter>1: SSPTXD←next lower bit, counter decrements.
  - On the tick launching bit 0 (counter=1), while SSPTXD←bit 0 and counter←0:
    - tx_empty=0: tx_pop=1, capture tx_data into the next-word register, SSPFSSOUT←1. This is the back-to-back case.
    - Otherwise SSPFSSOUT stays 0.
  - On the tick with counter=0:
    - If a next word is pending: SSPFSSOUT←0, load the shift register, SSPTXD←MSB, counter←DATA_WIDTH-1, stay in SHIFT; SSPOE_B stays low.
    - Else: SSPTXD←0, SSPOE_B←1, go to IDLE.
- **tx_pop:** asserted only on the PCLK cycle ending in the capturing tick; never on two consecutive ticks of the same frame; never when tx_empty=1.
- **tx_empty rising mid-frame:** no effect on the current frame.
- **Reset mid-frame:** CLEAR_B low clears all state immediately and asynchronously. The word in flight and any pending word are discarded (already popped, not re-queued).

## Timing

- Serial period is 2 PCLK; one bit per tick.
- Isolated frame: SSPFSSOUT high 1 period, then DATA_WIDTH data periods. The frame occupies (DATA_WIDTH+1)×2 PCLK; 18 PCLK for DATA_WIDTH=8.
- Back-to-back frames: no gap. SSPFSSOUT overlaps the previous LSB, giving DATA_WIDTH×2 PCLK per word (16).
- Start latency: tx_empty falling to SSPFSSOUT high is 1 or 2 PCLK edges, depending on SSPCLKOUT phase.
- Last LSB period to SSPOE_B high: SSPOE_B rises on the tick ending the LSB period.
- The receiver samples on SSPCLKOUT falling, mid-bit.

## Structure

- **Package ssp_pkg:**
  - state enum: IDLE, SYNC, SHIFT.
  - SSP_DATA_WIDTH default constant.
  - counter width, $clog2(DATA_WIDTH).
- **One sub-module, ssp_tx_shreg:** shift register plus next-word holding register plus pending flag, with load/shift/promote controls. The FSM and tick detection stay in ssp_tx_ctrl.
- **Clock divider:** not instantiated here. SSPCLKOUT is wired in at the SSP top level.

## Test plan

- **Reset:** hold CLEAR_B=0 for 4 PCLK with tx_empty=0 → all outputs at reset values, no tx_pop; release → first tick pops exactly once.
- **Single frame:** tx_data=8'hA5, then tx_empty=1 after the pop → SSPFSSOUT high 2 PCLK; SSPTXD sequence 1,0,1,0,0,1,0,1, each bit held 2 PCLK; SSPOE_B low 16 PCLK, then high; busy low afterwards.
- **Back-to-back:** FIFO holds 8'h3C, 8'hC3 → SSPFSSOUT high during the LSB of 8'h3C. Then 8'hC3 MSB follows with no gap; total 34 PCLK from first SSPFSSOUT rise to SSPOE_B rise; exactly 2 pops.
- **Phase:** tx_empty falls when SSPCLKOUT=1 vs SSPCLKOUT=0 → SSPFSSOUT rises at 2 vs 1 PCLK later; always coincident with SSPCLKOUT rising.
- **Reset mid-frame:** pulse CLEAR_B low after bit 4 of 8'hFF → outputs at reset values on the same edge; after release with tx_empty=1, no further activity.
- **DATA_WIDTH=4:** word 4'h9 → SSPTXD 1,0,0,1; frame 10 PCLK.
